// File: rtl/calc1_pkg.sv
// Shared command/response codes and sequencer state encoding for the calc1 port driver.
package calc1_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_LSH = 4'd5;
  localparam logic [3:0] CMD_RSH = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_OP1,
    ST_SEND_OP2,
    ST_WAIT_RSP,
    ST_RESPOND
  } seq_state_e;

endpackage

// File: rtl/calc1_req_fifo.sv
// Request queue for the port sequencer; head entry is read straight from storage so a pop
// can be acted on in the same cycle.
module calc1_req_fifo #(
  parameter int unsigned WIDTH = 68,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/calc1_port_sequencer.sv
// Drives queued (cmd, op1, op2) transactions onto one calc1 port using the two-cycle
// request protocol, then captures the port response (or a timeout) and pulses it upstream.
module calc1_port_sequencer
  import calc1_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [0:3]        req_cmd,
  input  logic [0:DATA_W-1] req_op1,
  input  logic [0:DATA_W-1] req_op2,
  output logic [0:3]        req_cmd_out,
  output logic [0:DATA_W-1] req_data_out,
  input  logic [0:1]        out_resp_in,
  input  logic [0:DATA_W-1] out_data_in,
  output logic              rsp_valid,
  output logic [0:1]        rsp_status,
  output logic [0:DATA_W-1] rsp_data,
  output logic              rsp_timeout,
  output logic              stray_resp,
  output logic              busy
);

  localparam int unsigned FW = 4 + 2*DATA_W;
  localparam int unsigned TW = $clog2(TIMEOUT);

  seq_state_e        state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [1:0]        status_q, status_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              tmo_q, tmo_d;
  logic              stray_q, stray_d;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FW-1:0]     fifo_rd;
  logic [3:0]        head_cmd;
  logic [DATA_W-1:0] head_op1;
  logic [DATA_W-1:0] head_op2;
  logic              resp_seen;

  calc1_req_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (c_clk),
    .reset   (reset),
    .push    (req_valid && req_ready),
    .pop     (fifo_pop),
    .wr_data ({req_cmd, req_op1, req_op2}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_cmd  = fifo_rd[FW-1 -: 4];
  assign head_op1  = fifo_rd[2*DATA_W-1 -: DATA_W];
  assign head_op2  = fifo_rd[DATA_W-1:0];
  assign resp_seen = (out_resp_in != RESP_NONE);

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    op2_d    = op2_q;
    timer_d  = timer_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    tmo_d    = tmo_q;
    stray_d  = stray_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_cmd != CMD_NOP) begin
            cmd_d   = head_cmd;
            data_d  = head_op1;
            op2_d   = head_op2;
            state_d = ST_SEND_OP1;
          end
        end
      end
      ST_SEND_OP1: begin
        cmd_d   = CMD_NOP;
        data_d  = op2_q;
        state_d = ST_SEND_OP2;
      end
      ST_SEND_OP2: begin
        cmd_d   = CMD_NOP;
        data_d  = '0;
        timer_d = '0;
        if (resp_seen) begin
          status_d = out_resp_in;
          rdata_d  = out_data_in;
          tmo_d    = 1'b0;
          state_d  = ST_RESPOND;
        end else begin
          state_d  = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        timer_d = timer_q + TW'(1);
        // A real response in the final timer cycle takes priority over the timeout.
        if (resp_seen) begin
          status_d = out_resp_in;
          rdata_d  = out_data_in;
          tmo_d    = 1'b0;
          state_d  = ST_RESPOND;
        end else if (timer_q == TW'(TIMEOUT-1)) begin
          status_d = RESP_NONE;
          rdata_d  = '0;
          tmo_d    = 1'b1;
          state_d  = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (resp_seen && (state_q == ST_IDLE || state_q == ST_SEND_OP1)) begin
      stray_d = 1'b1;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_NOP;
      data_q   <= '0;
      op2_q    <= '0;
      timer_q  <= '0;
      status_q <= RESP_NONE;
      rdata_q  <= '0;
      tmo_q    <= 1'b0;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      op2_q    <= op2_d;
      timer_q  <= timer_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      tmo_q    <= tmo_d;
      stray_q  <= stray_d;
    end
  end

  assign req_ready    = !fifo_full;
  assign req_cmd_out  = cmd_q;
  assign req_data_out = data_q;
  assign rsp_valid    = (state_q == ST_RESPOND);
  assign rsp_status   = status_q;
  assign rsp_data     = rdata_q;
  assign rsp_timeout  = tmo_q;
  assign stray_resp   = stray_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_calc1_port_sequencer.sv
// Directed bench for calc1_port_sequencer: a small calc1 responder answers each issued
// transaction three cycles after op2; expected values are hand-computed constants.
module tb_calc1_port_sequencer;
  import calc1_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic          c_clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [0:3]    req_cmd = '0;
  logic [0:DW-1] req_op1 = '0;
  logic [0:DW-1] req_op2 = '0;
  logic [0:3]    req_cmd_out;
  logic [0:DW-1] req_data_out;
  logic [0:1]    out_resp_in = '0;
  logic [0:DW-1] out_data_in = '0;
  logic          rsp_valid;
  logic [0:1]    rsp_status;
  logic [0:DW-1] rsp_data;
  logic          rsp_timeout;
  logic          stray_resp;
  logic          busy;

  calc1_port_sequencer #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cmd      (req_cmd),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_cmd_out  (req_cmd_out),
    .req_data_out (req_data_out),
    .out_resp_in  (out_resp_in),
    .out_data_in  (out_data_in),
    .rsp_valid    (rsp_valid),
    .rsp_status   (rsp_status),
    .rsp_data     (rsp_data),
    .rsp_timeout  (rsp_timeout),
    .stray_resp   (stray_resp),
    .busy         (busy)
  );

  always #5 c_clk = ~c_clk;

  int unsigned cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Responder / monitor state: only this block drives out_resp_in/out_data_in.
  logic        inject_stray = 1'b0;
  logic        reply_en     = 1'b1;
  logic        op2_next     = 1'b0;
  int          countdown    = 0;
  logic [3:0]  log_cmd;
  logic [31:0] log_op1;
  logic [1:0]  pend_code;
  logic [31:0] pend_data;
  int unsigned cmd_cyc = 0;
  int unsigned op2_cyc = 0;
  int unsigned push_cyc = 0;

  logic [3:0]  iss_cmd[$];
  logic [31:0] iss_op1[$];
  logic [31:0] iss_op2[$];
  logic [1:0]  rsp_st_q[$];
  logic [31:0] rsp_dt_q[$];
  logic        rsp_to_q[$];
  int unsigned rsp_cyc_q[$];

  function automatic void calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                               output logic [1:0] st, output logic [31:0] d);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (c)
      CMD_ADD: begin st = sum[32] ? RESP_ERR : RESP_OK; d = sum[32] ? '0 : sum[31:0]; end
      CMD_SUB: begin st = (b > a) ? RESP_ERR : RESP_OK; d = (b > a) ? '0 : a - b; end
      CMD_LSH: begin st = RESP_OK; d = a << b[4:0]; end
      CMD_RSH: begin st = RESP_OK; d = a >> b[4:0]; end
      default: begin st = RESP_ERR; d = '0; end
    endcase
  endfunction

  always @(posedge c_clk) begin
    #2;
    out_resp_in = '0;
    out_data_in = '0;
    if (countdown > 0) begin
      countdown--;
      if (countdown == 0) begin
        out_resp_in = pend_code;
        out_data_in = pend_data;
      end
    end
    if (req_cmd_out != CMD_NOP) begin
      log_cmd  = req_cmd_out;
      log_op1  = req_data_out;
      op2_next = 1'b1;
      cmd_cyc  = cyc;
    end else if (op2_next) begin
      op2_next = 1'b0;
      op2_cyc  = cyc;
      iss_cmd.push_back(log_cmd);
      iss_op1.push_back(log_op1);
      iss_op2.push_back(req_data_out);
      calc(log_cmd, log_op1, req_data_out, pend_code, pend_data);
      if (reply_en) countdown = 3;
    end
    if (inject_stray) out_resp_in = 2'd1;
    if (rsp_valid) begin
      rsp_st_q.push_back(rsp_status);
      rsp_dt_q.push_back(rsp_data);
      rsp_to_q.push_back(rsp_timeout);
      rsp_cyc_q.push_back(cyc);
    end
  end

  task automatic push(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned g = 0;
    req_valid = 1'b1;
    req_cmd   = c;
    req_op1   = a;
    req_op2   = b;
    while (!req_ready && g < 200) begin
      @(negedge c_clk);
      g++;
    end
    if (g == 200) check("push_ready", 64'(req_ready), 64'd1);
    push_cyc = cyc;
    @(negedge c_clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsps(input int unsigned n, input string tag);
    int unsigned g = 0;
    while (rsp_st_q.size() < n && g < 400) begin
      @(negedge c_clk);
      g++;
    end
    check({tag, "_arrived"}, 64'(rsp_st_q.size() >= n), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n0;
    int unsigned r0;

    reset = 1'b1;
    repeat (3) @(negedge c_clk);
    check("rst_cmd",   64'(req_cmd_out),  64'd0);
    check("rst_data",  64'(req_data_out), 64'd0);
    check("rst_valid", 64'(rsp_valid),    64'd0);
    check("rst_stat",  64'(rsp_status),   64'd0);
    check("rst_rdata", 64'(rsp_data),     64'd0);
    check("rst_tmo",   64'(rsp_timeout),  64'd0);
    check("rst_stray", 64'(stray_resp),   64'd0);
    check("rst_busy",  64'(busy),         64'd0);
    check("rst_ready", 64'(req_ready),    64'd1);
    reset = 1'b0;
    @(negedge c_clk);

    // 1: ADD 255,1 -> 256, latency and protocol framing
    push(CMD_ADD, 32'd255, 32'd1);
    wait_rsps(1, "t1");
    check("t1_latency", 64'(cmd_cyc - push_cyc), 64'd2);
    check("t1_cmd",     64'(iss_cmd[0]),  64'd1);
    check("t1_op1",     64'(iss_op1[0]),  64'd255);
    check("t1_op2",     64'(iss_op2[0]),  64'd1);
    check("t1_status",  64'(rsp_st_q[0]), 64'd1);
    check("t1_data",    64'(rsp_dt_q[0]), 64'd256);
    check("t1_tmo",     64'(rsp_to_q[0]), 64'd0);
    check("t1_rsp_lat", 64'(rsp_cyc_q[0] - op2_cyc), 64'd4);
    repeat (3) @(negedge c_clk);
    check("t1_one_pulse", 64'(rsp_st_q.size()), 64'd1);
    check("t1_idle", 64'(busy), 64'd0);

    // 2: five back-to-back pushes into a depth-4 queue
    n0 = iss_cmd.size();
    r0 = rsp_st_q.size();
    for (int i = 1; i <= 5; i++) push(CMD_ADD, 32'(10*i), 32'(i));
    check("t2_full_ready", 64'(req_ready), 64'd0);
    check("t2_busy",       64'(busy),      64'd1);
    wait_rsps(r0 + 5, "t2");
    for (int i = 1; i <= 5; i++) begin
      check("t2_op1",  64'(iss_op1[n0+i-1]),  64'(10*i));
      check("t2_op2",  64'(iss_op2[n0+i-1]),  64'(i));
      check("t2_data", 64'(rsp_dt_q[r0+i-1]), 64'(11*i));
    end
    repeat (2) @(negedge c_clk);

    // 3: SUB underflow returns error status unchanged
    r0 = rsp_st_q.size();
    push(CMD_SUB, 32'd1, 32'd2);
    wait_rsps(r0 + 1, "t3");
    check("t3_status", 64'(rsp_st_q[r0]), 64'd2);
    check("t3_data",   64'(rsp_dt_q[r0]), 64'd0);
    check("t3_tmo",    64'(rsp_to_q[r0]), 64'd0);
    repeat (2) @(negedge c_clk);

    // 4: no reply -> timeout after TMO cycles in WAIT_RSP, then normal traffic resumes
    reply_en = 1'b0;
    r0 = rsp_st_q.size();
    push(CMD_ADD, 32'd7, 32'd8);
    wait_rsps(r0 + 1, "t4");
    check("t4_tmo",     64'(rsp_to_q[r0]), 64'd1);
    check("t4_status",  64'(rsp_st_q[r0]), 64'd0);
    check("t4_data",    64'(rsp_dt_q[r0]), 64'd0);
    check("t4_wait_len", 64'(rsp_cyc_q[r0] - op2_cyc), 64'(TMO + 1));
    reply_en = 1'b1;
    push(CMD_ADD, 32'd2, 32'd3);
    wait_rsps(r0 + 2, "t4b");
    check("t4b_status", 64'(rsp_st_q[r0+1]), 64'd1);
    check("t4b_data",   64'(rsp_dt_q[r0+1]), 64'd5);
    check("t4b_tmo",    64'(rsp_to_q[r0+1]), 64'd0);
    repeat (2) @(negedge c_clk);

    // 5: reset while in SEND_OP2 with two entries queued
    reply_en = 1'b0;
    n0 = iss_cmd.size();
    r0 = rsp_st_q.size();
    push(CMD_ADD, 32'd1, 32'd1);
    push(CMD_ADD, 32'd2, 32'd2);
    push(CMD_ADD, 32'd3, 32'd3);
    check("t5_in_op2", 64'(req_data_out), 64'd1);
    reset = 1'b1;
    @(negedge c_clk);
    check("t5_cmd",   64'(req_cmd_out),  64'd0);
    check("t5_data",  64'(req_data_out), 64'd0);
    check("t5_busy",  64'(busy),         64'd0);
    check("t5_valid", 64'(rsp_valid),    64'd0);
    reset = 1'b0;
    repeat (TMO + 10) @(negedge c_clk);
    check("t5_issued",  64'(iss_cmd.size()),  64'(n0 + 1));
    check("t5_no_rsp",  64'(rsp_st_q.size()), 64'(r0));
    check("t5_busy_after", 64'(busy), 64'd0);
    reply_en = 1'b1;

    // 6: stray response while IDLE, then a NOP entry followed by LSH 1,4
    check("t6_stray_clear", 64'(stray_resp), 64'd0);
    inject_stray = 1'b1;
    @(negedge c_clk);
    inject_stray = 1'b0;
    @(negedge c_clk);
    check("t6_stray_set", 64'(stray_resp), 64'd1);
    n0 = iss_cmd.size();
    r0 = rsp_st_q.size();
    push(CMD_NOP, 32'd5, 32'd6);
    push(CMD_LSH, 32'd1, 32'd4);
    wait_rsps(r0 + 1, "t6");
    check("t6_cmd",    64'(iss_cmd[n0]),  64'(CMD_LSH));
    check("t6_op1",    64'(iss_op1[n0]),  64'd1);
    check("t6_op2",    64'(iss_op2[n0]),  64'd4);
    check("t6_status", 64'(rsp_st_q[r0]), 64'd1);
    check("t6_data",   64'(rsp_dt_q[r0]), 64'd16);
    repeat (3) @(negedge c_clk);
    check("t6_issued_once", 64'(iss_cmd.size()), 64'(n0 + 1));
    check("t6_stray_held",  64'(stray_resp),      64'd1);
    check("t6_idle",        64'(busy),            64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
